// File: rtl/simon_uart_frame_ctrl.sv
// rtl/simon_uart_frame_ctrl.sv - UART command/frame sequencer for the Simon 32/64 core
// Optional inter-byte timeout is built when SIMON_CTRL_TIMEOUT_EN is defined.
module simon_uart_frame_ctrl #(
    parameter int BLOCK_BYTES    = 4,
    parameter int KEY_BYTES      = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic                     core_start,
    output logic                     core_decrypt,
    output logic [8*KEY_BYTES-1:0]   core_key,
    output logic [8*BLOCK_BYTES-1:0] core_block_in,
    input  logic                     core_done,
    input  logic [8*BLOCK_BYTES-1:0] core_block_out,
    output logic [3:0]               status,
    output logic                     err
);
    localparam int KW        = 8 * KEY_BYTES;
    localparam int BW        = 8 * BLOCK_BYTES;
    localparam int MAX_BYTES = (KEY_BYTES > BLOCK_BYTES) ? KEY_BYTES : BLOCK_BYTES;
    localparam int CNT_W     = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0] KEY_LAST = CNT_W'(KEY_BYTES - 1);
    localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(BLOCK_BYTES - 1);
    localparam logic [CNT_W-1:0] BLK_CNT  = CNT_W'(BLOCK_BYTES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [7:0] CMD_KEY = 8'h4B;
    localparam logic [7:0] CMD_ENC = 8'h45;
    localparam logic [7:0] CMD_DEC = 8'h44;
    localparam logic [7:0] ACK     = 8'h06;
    localparam logic [7:0] NAK     = 8'h15;

    typedef enum logic [3:0] {
        IDLE      = 4'h0,
        RX_KEY    = 4'h1,
        RX_BLOCK  = 4'h2,
        START     = 4'h3,
        WAIT_CORE = 4'h4,
        TX_LOAD   = 4'h5,
        TX_WAIT   = 4'h6
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_dec_q, is_dec_d;
    logic [KW-1:0]     key_sh_q, key_sh_d;
    logic [BW-1:0]     blk_sh_q, blk_sh_d;
    logic              key_valid_q, key_valid_d;
    logic [KW-1:0]     core_key_q, core_key_d;
    logic [BW-1:0]     core_block_in_q, core_block_in_d;
    logic              core_decrypt_q, core_decrypt_d;
    logic              core_start_q, core_start_d;
    logic              tx_start_q, tx_start_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [BW-1:0]     reply_q, reply_d;
    logic              err_q, err_d;
    logic              guard_q, guard_d;
`ifdef SIMON_CTRL_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]   to_q, to_d;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        is_dec_d        = is_dec_q;
        key_sh_d        = key_sh_q;
        blk_sh_d        = blk_sh_q;
        key_valid_d     = key_valid_q;
        core_key_d      = core_key_q;
        core_block_in_d = core_block_in_q;
        core_decrypt_d  = core_decrypt_q;
        core_start_d    = 1'b0;
        tx_start_d      = 1'b0;
        tx_data_d       = tx_data_q;
        reply_d         = reply_q;
        err_d           = err_q;
        guard_d         = guard_q;

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    cnt_d = '0;
                    if (rx_data == CMD_KEY) begin
                        state_d = RX_KEY;
                        err_d   = 1'b0;
                    end else if (rx_data == CMD_ENC || rx_data == CMD_DEC) begin
                        state_d  = RX_BLOCK;
                        err_d    = 1'b0;
                        is_dec_d = (rx_data == CMD_DEC);
                    end else begin
                        state_d = TX_LOAD;
                        err_d   = 1'b1;
                        reply_d = {NAK, {(BW-8){1'b0}}};
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            RX_KEY: begin
                if (rx_valid) begin
                    key_sh_d = {key_sh_q[KW-9:0], rx_data};
                    cnt_d    = cnt_q + CNT_ONE;
                    // Commit only on the final byte so a partial key never reaches the core.
                    if (cnt_q == KEY_LAST) begin
                        core_key_d  = key_sh_d;
                        key_valid_d = 1'b1;
                        reply_d     = {ACK, {(BW-8){1'b0}}};
                        cnt_d       = CNT_ONE;
                        state_d     = TX_LOAD;
                    end
                end
            end
            RX_BLOCK: begin
                if (rx_valid) begin
                    blk_sh_d = {blk_sh_q[BW-9:0], rx_data};
                    cnt_d    = cnt_q + CNT_ONE;
                    if (cnt_q == BLK_LAST) begin
                        if (key_valid_q) begin
                            core_block_in_d = blk_sh_d;
                            core_decrypt_d  = is_dec_q;
                            core_start_d    = 1'b1;
                            state_d         = START;
                        end else begin
                            err_d   = 1'b1;
                            reply_d = {NAK, {(BW-8){1'b0}}};
                            cnt_d   = CNT_ONE;
                            state_d = TX_LOAD;
                        end
                    end
                end
            end
            START: state_d = WAIT_CORE;
            WAIT_CORE: begin
                if (core_done) begin
                    reply_d = core_block_out;
                    cnt_d   = BLK_CNT;
                    state_d = TX_LOAD;
                end
            end
            TX_LOAD: begin
                if (!tx_busy) begin
                    tx_start_d = 1'b1;
                    tx_data_d  = reply_q[BW-1 -: 8];
                    reply_d    = reply_q << 8;
                    cnt_d      = cnt_q - CNT_ONE;
                    guard_d    = 1'b1;
                    state_d    = TX_WAIT;
                end
            end
            TX_WAIT: begin
                // The transmitter may not raise busy until a cycle after tx_start.
                guard_d = 1'b0;
                if (!guard_q && !tx_busy) begin
                    state_d = (cnt_q != '0) ? TX_LOAD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rx_valid && (state_q == START || state_q == WAIT_CORE ||
                         state_q == TX_LOAD || state_q == TX_WAIT)) begin
            err_d = 1'b1;
        end

`ifdef SIMON_CTRL_TIMEOUT_EN
        to_d = '0;
        if ((state_q == RX_KEY || state_q == RX_BLOCK) && !rx_valid) begin
            if (to_q == TO_LAST) begin
                state_d  = IDLE;
                key_sh_d = '0;
                blk_sh_d = '0;
                err_d    = 1'b1;
            end else begin
                to_d = to_q + TO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            is_dec_q        <= 1'b0;
            key_sh_q        <= '0;
            blk_sh_q        <= '0;
            key_valid_q     <= 1'b0;
            core_key_q      <= '0;
            core_block_in_q <= '0;
            core_decrypt_q  <= 1'b0;
            core_start_q    <= 1'b0;
            tx_start_q      <= 1'b0;
            tx_data_q       <= 8'h00;
            reply_q         <= '0;
            err_q           <= 1'b0;
            guard_q         <= 1'b0;
`ifdef SIMON_CTRL_TIMEOUT_EN
            to_q            <= '0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            is_dec_q        <= is_dec_d;
            key_sh_q        <= key_sh_d;
            blk_sh_q        <= blk_sh_d;
            key_valid_q     <= key_valid_d;
            core_key_q      <= core_key_d;
            core_block_in_q <= core_block_in_d;
            core_decrypt_q  <= core_decrypt_d;
            core_start_q    <= core_start_d;
            tx_start_q      <= tx_start_d;
            tx_data_q       <= tx_data_d;
            reply_q         <= reply_d;
            err_q           <= err_d;
            guard_q         <= guard_d;
`ifdef SIMON_CTRL_TIMEOUT_EN
            to_q            <= to_d;
`endif
        end
    end

    assign tx_start      = tx_start_q;
    assign tx_data       = tx_data_q;
    assign core_start    = core_start_q;
    assign core_decrypt  = core_decrypt_q;
    assign core_key      = core_key_q;
    assign core_block_in = core_block_in_q;
    assign status        = state_q;
    assign err           = err_q;
endmodule
